// File: rtl/job_arb_pkg.sv
// job_arb_pkg: shared state encoding, default timing constants and width helper
// for the job engine arbiter.
package job_arb_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        RUN     = 3'd2,
        KILL    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    localparam int DEF_TIMEOUT   = 15;
    localparam int DEF_KILL_HOLD = 2;

    // Never returns less than 1 so every counter has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; the first set request at or after
// ptr (circularly) wins.
module rr_pick
    import job_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            valid
);
    always_comb begin
        int j;
        idx = '0;
        j = 0;
        // Walk from the farthest offset back so the nearest set bit lands last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NREQ;
            if (req[j]) idx = PW'(j);
        end
        valid = |req;
        onehot = '0;
        onehot[idx] = valid;
    end
endmodule

// File: rtl/job_engine_arbiter.sv
// job_engine_arbiter: round-robin owner of a shared go/kill/done engine with a watchdog
// and cancel-driven abort. Define JOB_ARB_STATS_EN to add stat_done/stat_abort counters.
module job_engine_arbiter
    import job_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int KILL_HOLD = DEF_KILL_HOLD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] ack,
    output logic            aborted,
    output logic            busy,
    output logic            eng_go,
    output logic            eng_kill,
`ifdef JOB_ARB_STATS_EN
    output logic [15:0]     stat_done,
    output logic [15:0]     stat_abort,
`endif
    input  logic            eng_done
);
    localparam int PW = clog2(NREQ);
    localparam int TW = clog2(TIMEOUT + 1);
    localparam int KW = clog2(KILL_HOLD);

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, win_idx;
    logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d, win_onehot;
    logic [TW-1:0]   timer_q, timer_d;
    logic [KW-1:0]   kcnt_q, kcnt_d;
    logic            aborted_q, aborted_d, busy_q, busy_d;
    logic            go_q, go_d, kill_q, kill_d, win_valid;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (win_onehot),
        .idx    (win_idx),
        .valid  (win_valid)
    );

    // timer_q holds the 1-based RUN cycle number, so TIMEOUT RUN cycles elapse before kill.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timer_d   = '0;
        kcnt_d    = '0;
        ack_d     = '0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = LAUNCH;
                    ptr_d   = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
                end
            end
            LAUNCH: begin
                state_d = RUN;
                timer_d = TW'(1);
            end
            RUN: begin
                if (eng_done) begin
                    state_d = IDLE;
                    ack_d   = gnt_q;
                end else if ((req & gnt_q) == '0 || timer_q == TW'(TIMEOUT)) begin
                    state_d = KILL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            KILL: begin
                if (kcnt_q == KW'(KILL_HOLD - 1)) state_d = RECOVER;
                else kcnt_d = kcnt_q + 1'b1;
            end
            RECOVER: begin
                state_d   = IDLE;
                ack_d     = gnt_q;
                aborted_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        gnt_d  = (state_d == IDLE) ? '0 : (state_q == IDLE) ? win_onehot : gnt_q;
        go_d   = state_d == LAUNCH;
        kill_d = state_d == KILL;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            timer_q   <= '0;
            kcnt_q    <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            go_q      <= 1'b0;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            timer_q   <= timer_d;
            kcnt_q    <= kcnt_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            go_q      <= go_d;
            kill_q    <= kill_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign aborted  = aborted_q;
    assign busy     = busy_q;
    assign eng_go   = go_q;
    assign eng_kill = kill_q;

`ifdef JOB_ARB_STATS_EN
    logic [15:0] stat_done_q, stat_done_d, stat_abort_q, stat_abort_d;

    always_comb begin
        stat_done_d  = (ack_d != '0 && !aborted_d && stat_done_q != 16'hFFFF) ? stat_done_q + 1'b1 : stat_done_q;
        stat_abort_d = (aborted_d && stat_abort_q != 16'hFFFF) ? stat_abort_q + 1'b1 : stat_abort_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_done_q  <= '0;
            stat_abort_q <= '0;
        end else begin
            stat_done_q  <= stat_done_d;
            stat_abort_q <= stat_abort_d;
        end
    end

    assign stat_done  = stat_done_q;
    assign stat_abort = stat_abort_q;
`endif
endmodule
